// File: rtl/mem_txn_monitor.sv
// Passive transaction monitor for one processor memory port: completion strobes for the shadow-memory
// checker plus sticky protocol/timeout flags. Optional stability check: MEM_MON_STABILITY_CHECK_EN.
module mem_txn_monitor #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [31:0]          mem_address,
   input  logic [3:0]           mem_byte_enable,
   input  logic [31:0]          mem_wdata,
   input  logic                 mem_resp,
   input  logic [31:0]          mem_rdata,
   output logic                 chk_valid,
   output logic                 chk_write,
   output logic [31:0]          chk_addr,
   output logic [31:0]          chk_rdata,
   output logic [3:0]           chk_wmask,
   output logic [31:0]          chk_wdata,
   output logic                 protocol_error,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] txn_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND_RD = 2'd1,
      PEND_WR = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [15:0]            wait_cnt_r;
   logic [15:0]            wait_cnt_nxt_s;
   logic [31:0]            lat_addr_r;
   logic [3:0]             lat_be_r;
   logic [31:0]            lat_wdata_r;

   logic                   capture_s;
   logic                   done_rd_s;
   logic                   done_wr_s;
   logic                   proto_err_s;
   logic                   tmo_s;
   logic                   stab_err_s;
   logic                   req_held_s;

   logic [31:0]            src_addr_s;
   logic [3:0]             src_be_s;
   logic [31:0]            src_wdata_s;

   logic                   chk_valid_nxt_s;
   logic                   chk_write_nxt_s;
   logic [31:0]            chk_addr_nxt_s;
   logic [31:0]            chk_rdata_nxt_s;
   logic [3:0]             chk_wmask_nxt_s;
   logic [31:0]            chk_wdata_nxt_s;
   logic                   protocol_error_nxt_s;
   logic                   timeout_nxt_s;
   logic [CNT_WIDTH-1:0]   txn_count_nxt_s;

   // The pending request counts as held only while its own type is still asserted.
   assign req_held_s = (state_r == PEND_RD) ? mem_read : mem_write;

   // FSM state and wait-counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         wait_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Next-state, completion, error and timeout decode
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      capture_s      = 1'b0;
      done_rd_s      = 1'b0;
      done_wr_s      = 1'b0;
      proto_err_s    = 1'b0;
      tmo_s          = 1'b0;
      case (state_r)
         IDLE: begin
            if (mem_read && mem_write) begin
               proto_err_s = 1'b1;
            end else if (mem_read || mem_write) begin
               capture_s      = 1'b1;
               wait_cnt_nxt_s = 16'd0;
               if (mem_resp) begin
                  done_rd_s = mem_read;
                  done_wr_s = mem_write;
               end else begin
                  state_nxt_s = mem_read ? PEND_RD : PEND_WR;
               end
            end else begin
               proto_err_s = mem_resp;
            end
         end
         PEND_RD, PEND_WR: begin
            // Both request lines high is illegal everywhere; the pending context is left untouched.
            if (mem_read && mem_write) begin
               proto_err_s = 1'b1;
            end else if (mem_resp) begin
               done_rd_s   = (state_r == PEND_RD);
               done_wr_s   = (state_r == PEND_WR);
               state_nxt_s = IDLE;
            end else if (!req_held_s) begin
               proto_err_s = 1'b1;
               state_nxt_s = IDLE;
            end else if (wait_cnt_r == TIMEOUT_LIMIT) begin
               tmo_s       = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 16'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

`ifdef MEM_MON_STABILITY_CHECK_EN
   // Request fields must not move while the transaction is outstanding
   always_comb begin
      stab_err_s = 1'b0;
      if (state_r == PEND_RD) begin
         stab_err_s = (mem_address != lat_addr_r);
      end else if (state_r == PEND_WR) begin
         stab_err_s = (mem_address != lat_addr_r) || (mem_byte_enable != lat_be_r) ||
                      (mem_wdata != lat_wdata_r);
      end else begin
         stab_err_s = 1'b0;
      end
   end
`else
   assign stab_err_s = 1'b0;
`endif

   // Request latch, loaded on capture from IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_addr_r  <= 32'h0000_0000;
         lat_be_r    <= 4'h0;
         lat_wdata_r <= 32'h0000_0000;
      end else if (capture_s) begin
         lat_addr_r  <= mem_address;
         lat_be_r    <= mem_byte_enable;
         lat_wdata_r <= mem_wdata;
      end else begin
         lat_addr_r  <= lat_addr_r;
         lat_be_r    <= lat_be_r;
         lat_wdata_r <= lat_wdata_r;
      end
   end

   // Zero-wait completions happen in IDLE, before the latch holds the request.
   assign src_addr_s  = (state_r == IDLE) ? mem_address     : lat_addr_r;
   assign src_be_s    = (state_r == IDLE) ? mem_byte_enable : lat_be_r;
   assign src_wdata_s = (state_r == IDLE) ? mem_wdata       : lat_wdata_r;

   // Next values of the registered checker outputs
   always_comb begin
      chk_valid_nxt_s      = done_rd_s;
      chk_write_nxt_s      = done_wr_s;
      chk_addr_nxt_s       = chk_addr;
      chk_rdata_nxt_s      = chk_rdata;
      chk_wmask_nxt_s      = chk_wmask;
      chk_wdata_nxt_s      = chk_wdata;
      txn_count_nxt_s      = txn_count;
      protocol_error_nxt_s = protocol_error | proto_err_s | stab_err_s;
      timeout_nxt_s        = timeout | tmo_s;
      if (done_rd_s || done_wr_s) begin
         chk_addr_nxt_s  = src_addr_s & 32'hFFFF_FFFC;
         txn_count_nxt_s = txn_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         chk_addr_nxt_s  = chk_addr;
         txn_count_nxt_s = txn_count;
      end
      if (done_rd_s) begin
         chk_rdata_nxt_s = mem_rdata;
      end else begin
         chk_rdata_nxt_s = chk_rdata;
      end
      if (done_wr_s) begin
         chk_wmask_nxt_s = src_be_s;
         chk_wdata_nxt_s = src_wdata_s;
      end else begin
         chk_wmask_nxt_s = chk_wmask;
         chk_wdata_nxt_s = chk_wdata;
      end
   end

   // Registered checker outputs and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_valid      <= 1'b0;
         chk_write      <= 1'b0;
         chk_addr       <= 32'h0000_0000;
         chk_rdata      <= 32'h0000_0000;
         chk_wmask      <= 4'h0;
         chk_wdata      <= 32'h0000_0000;
         protocol_error <= 1'b0;
         timeout        <= 1'b0;
         txn_count      <= {CNT_WIDTH{1'b0}};
      end else begin
         chk_valid      <= chk_valid_nxt_s;
         chk_write      <= chk_write_nxt_s;
         chk_addr       <= chk_addr_nxt_s;
         chk_rdata      <= chk_rdata_nxt_s;
         chk_wmask      <= chk_wmask_nxt_s;
         chk_wdata      <= chk_wdata_nxt_s;
         protocol_error <= protocol_error_nxt_s;
         timeout        <= timeout_nxt_s;
         txn_count      <= txn_count_nxt_s;
      end
   end

endmodule

// File: tb/tb_mem_txn_monitor.sv
// Self-checking bench for mem_txn_monitor: transaction-level reference model driven by randomized
// and directed transactions; expectations adapt to MEM_MON_STABILITY_CHECK_EN when defined.
module tb_mem_txn_monitor;

   localparam int TMO = 8;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_address;
   logic [3:0]    mem_byte_enable;
   logic [31:0]   mem_wdata;
   logic          mem_resp;
   logic [31:0]   mem_rdata;
   logic          chk_valid;
   logic          chk_write;
   logic [31:0]   chk_addr;
   logic [31:0]   chk_rdata;
   logic [3:0]    chk_wmask;
   logic [31:0]   chk_wdata;
   logic          protocol_error;
   logic          timeout;
   logic [CW-1:0] txn_count;

   mem_txn_monitor #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .chk_valid(chk_valid), .chk_write(chk_write), .chk_addr(chk_addr),
      .chk_rdata(chk_rdata), .chk_wmask(chk_wmask), .chk_wdata(chk_wdata),
      .protocol_error(protocol_error), .timeout(timeout), .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;

   // Reference model: what the checker should currently be showing
   int          exp_cnt = 0;
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] exp_rdata = 32'h0;
   logic [3:0]  exp_wmask = 4'h0;
   logic [31:0] exp_wdata = 32'h0;
   bit          exp_perr = 1'b0;
   bit          exp_tmo = 1'b0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input bit v, input bit w);
      chk_eq({tag, "_valid"}, chk_valid, v);
      chk_eq({tag, "_write"}, chk_write, w);
      chk_eq({tag, "_addr"}, chk_addr, exp_addr);
      chk_eq({tag, "_rdata"}, chk_rdata, exp_rdata);
      chk_eq({tag, "_wmask"}, chk_wmask, exp_wmask);
      chk_eq({tag, "_wdata"}, chk_wdata, exp_wdata);
      chk_eq({tag, "_perr"}, protocol_error, exp_perr);
      chk_eq({tag, "_tmo"}, timeout, exp_tmo);
      chk_eq({tag, "_count"}, txn_count, exp_cnt % 256);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_cnt = 0; exp_addr = 32'h0; exp_rdata = 32'h0;
      exp_wmask = 4'h0; exp_wdata = 32'h0; exp_perr = 1'b0; exp_tmo = 1'b0;
   endtask

   task automatic drive_quiet();
      mem_read = 1'b0; mem_write = 1'b0; mem_resp = 1'b0;
   endtask

   task automatic drive_idle(input string tag);
      drive_quiet();
      step();
      check_outputs(tag, 1'b0, 1'b0);
   endtask

   task automatic reset_dut();
      drive_quiet();
      rst_n = 1'b0;
      #1;
      clear_model();
      check_outputs("reset", 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
   endtask

   // One transaction: `waits` request cycles without resp, then a resp cycle.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits,
                          input bit wiggle);
      bit stab_hit = 1'b0;
`ifdef MEM_MON_STABILITY_CHECK_EN
      stab_hit = wiggle;
`endif
      mem_read = !wr; mem_write = wr; mem_address = addr;
      mem_byte_enable = be; mem_wdata = wd; mem_resp = 1'b0;
      for (int i = 0; i < waits; i++) begin
         mem_rdata = $urandom;
         if (wiggle && i > 0) mem_address = addr ^ 32'h0000_0040;
         step();
         if (stab_hit && i > 0) exp_perr = 1'b1;
         check_outputs("wait", 1'b0, 1'b0);
      end
      if (wiggle && waits > 0) mem_address = addr ^ 32'h0000_0040;
      mem_resp = 1'b1; mem_rdata = rd;
      step();
      drive_quiet();
      mem_rdata = $urandom;
      if (stab_hit && waits > 0) exp_perr = 1'b1;
      exp_cnt++;
      exp_addr = {addr[31:2], 2'b00};
      if (wr) begin
         exp_wmask = be; exp_wdata = wd;
      end else begin
         exp_rdata = rd;
      end
      check_outputs(wr ? "wr_done" : "rd_done", !wr, wr);
   endtask

   // Read held with no response: timeout once TMO pending cycles have elapsed without resp.
   task automatic run_timeout(input logic [31:0] addr);
      mem_read = 1'b1; mem_write = 1'b0; mem_address = addr; mem_resp = 1'b0;
      for (int i = 0; i <= TMO + 1; i++) begin
         step();
         if (i == TMO + 1) exp_tmo = 1'b1;
         check_outputs("tmo_wait", 1'b0, 1'b0);
      end
      drive_idle("tmo_after");
   endtask

   initial begin
      rst_n = 1'b0;
      drive_quiet();
      mem_address = 32'h0; mem_byte_enable = 4'h0; mem_wdata = 32'h0; mem_rdata = 32'h0;
      #12;
      check_outputs("por", 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      drive_idle("post_reset");

      // Directed scenarios
      run_txn(1'b0, 32'h0000_0064, 4'h0, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
      drive_idle("gap1");
      run_txn(1'b1, 32'h0000_0103, 4'b0110, 32'h1122_3344, 32'h0, 0, 1'b0);
      drive_idle("gap2");
      reset_dut();
      run_txn(1'b0, 32'h0000_0010, 4'h0, 32'h0, $urandom, 1, 1'b0);
      run_txn(1'b0, 32'h0000_0014, 4'h0, 32'h0, $urandom, 1, 1'b0);
      drive_idle("b2b_end");

      // Randomized transactions, enough completions to wrap the 8-bit counter
      for (int n = 0; n < 300; n++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
                 $urandom_range(0, 6), 1'b0);
         if ($urandom_range(0, 3) == 0) drive_idle("rnd_gap");
      end
      drive_idle("rnd_end");

      // Response arriving exactly when the wait counter reaches the limit completes normally
      run_txn(1'b0, 32'h0000_0A08, 4'h0, 32'h0, 32'hCAFE_F00D, TMO + 1, 1'b0);
      drive_idle("tmo_edge");
      run_timeout(32'h0000_0B00);
      run_txn(1'b1, 32'h0000_0C04, 4'hF, 32'h5566_7788, 32'h0, 2, 1'b0);
      drive_idle("post_tmo");

      // Read and write together
      reset_dut();
      mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h0000_0200;
      step();
      exp_perr = 1'b1;
      check_outputs("rw_both", 1'b0, 1'b0);
      drive_idle("rw_both_after");

      // Stray response in IDLE
      reset_dut();
      mem_resp = 1'b1;
      step();
      exp_perr = 1'b1;
      check_outputs("stray_resp", 1'b0, 1'b0);
      drive_idle("stray_after");

      // Request dropped while pending
      reset_dut();
      mem_read = 1'b1; mem_address = 32'h0000_0300;
      step();
      check_outputs("drop_cap", 1'b0, 1'b0);
      step();
      check_outputs("drop_pend", 1'b0, 1'b0);
      mem_read = 1'b0;
      step();
      exp_perr = 1'b1;
      check_outputs("drop", 1'b0, 1'b0);
      drive_idle("drop_after");

      // Address moves while a write is pending
      reset_dut();
      run_txn(1'b1, 32'h0000_2004, 4'hF, 32'hA5A5_5A5A, 32'h0, 3, 1'b1);
      drive_idle("wiggle_after");

      // Asynchronous reset in the middle of a read
      reset_dut();
      run_txn(1'b1, 32'h0000_4008, 4'h9, 32'h0BAD_F00D, 32'h0, 1, 1'b0);
      mem_read = 1'b1; mem_address = 32'h0000_5000;
      step();
      check_outputs("mid_cap", 1'b0, 1'b0);
      step();
      check_outputs("mid_pend", 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      clear_model();
      check_outputs("mid_rst", 1'b0, 1'b0);
      mem_read = 1'b0; mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      rst_n = 1'b1;
      mem_resp = 1'b0;
      check_outputs("mid_rst_hold", 1'b0, 1'b0);
      drive_idle("mid_rst_after1");
      drive_idle("mid_rst_after2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
